// File: rtl/dcf77_pkg.sv
// rtl/dcf77_pkg.sv - shared constants, types and range helper for the DCF77 time decoder
package dcf77_pkg;

    localparam int FRAME_BITS = 59;

    // Second-bit positions within the minute frame
    localparam logic [5:0] MARKER0  = 6'd0;
    localparam logic [5:0] TZ_ANN   = 6'd16;
    localparam logic [5:0] CEST     = 6'd17;
    localparam logic [5:0] CET      = 6'd18;
    localparam logic [5:0] LEAP     = 6'd19;
    localparam logic [5:0] MARKER20 = 6'd20;
    localparam logic [5:0] MIN_LO   = 6'd21;
    localparam logic [5:0] MIN_PAR  = 6'd28;
    localparam logic [5:0] HOUR_LO  = 6'd29;
    localparam logic [5:0] HOUR_PAR = 6'd35;
    localparam logic [5:0] DATE_LO  = 6'd36;
    localparam logic [5:0] DATE_PAR = 6'd58;

    // Rejection causes, lowest number wins when several apply
    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_MARKER = 3'd1;
    localparam logic [2:0] ERR_TZ     = 3'd2;
    localparam logic [2:0] ERR_PMIN   = 3'd3;
    localparam logic [2:0] ERR_PHOUR  = 3'd4;
    localparam logic [2:0] ERR_PDATE  = 3'd5;
    localparam logic [2:0] ERR_RANGE  = 3'd6;

    localparam logic [5:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        EVAL    = 2'd2,
        PUBLISH = 2'd3
    } dcf_state_t;

    typedef struct packed {
        logic [6:0] minute;
        logic [5:0] hour;
        logic [5:0] day;
        logic [2:0] weekday;
        logic [4:0] month;
        logic [7:0] year;
    } dcf_fields_t;

    // True when every BCD digit is 0-9 and each field lies in its calendar range
    function automatic logic fields_in_range(input dcf_fields_t f);
        logic ok;
        ok = 1'b1;
        if (f.minute[3:0] > 4'd9 || f.minute[6:4] > 3'd5) ok = 1'b0;
        if (f.hour[3:0] > 4'd9) ok = 1'b0;
        if (f.hour[5:4] == 2'd3 || (f.hour[5:4] == 2'd2 && f.hour[3:0] > 4'd3)) ok = 1'b0;
        if (f.day[3:0] > 4'd9 || f.day == 6'h00) ok = 1'b0;
        if (f.day[5:4] == 2'd3 && f.day[3:0] > 4'd1) ok = 1'b0;
        if (f.weekday == 3'd0) ok = 1'b0;
        if (f.month[3:0] > 4'd9 || f.month == 5'h00) ok = 1'b0;
        if (f.month[4] && f.month[3:0] > 4'd2) ok = 1'b0;
        if (f.year[3:0] > 4'd9 || f.year[7:4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dcf77_time_decoder_if.sv
// rtl/dcf77_time_decoder_if.sv - frame input and decoded time output bundle
interface dcf77_time_decoder_if;
    import dcf77_pkg::*;

    logic                  dcf_sec;
    logic [FRAME_BITS-1:0] dcf_outputbits;
    logic                  frame_stb;
    logic                  frame_err;
    logic [2:0]            err_code;
    logic                  time_valid;
    logic [6:0]            minute;
    logic [5:0]            hour;
    logic [5:0]            day;
    logic [2:0]            weekday;
    logic [4:0]            month;
    logic [7:0]            year;
    logic                  cest;
    logic                  tz_announce;
    logic                  leap_announce;
    logic [5:0]            second;

    modport master (
        output dcf_sec, dcf_outputbits,
        input  frame_stb, frame_err, err_code, time_valid, minute, hour, day,
               weekday, month, year, cest, tz_announce, leap_announce, second
    );

    modport slave (
        input  dcf_sec, dcf_outputbits,
        output frame_stb, frame_err, err_code, time_valid, minute, hour, day,
               weekday, month, year, cest, tz_announce, leap_announce, second
    );

endinterface

// File: rtl/dcf77_second_counter.sv
// rtl/dcf77_second_counter.sv - one-second divider, saturating seconds and stale-time timeout
module dcf77_second_counter
    import dcf77_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 16000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    output logic [5:0] second_o,
    output logic       timeout_o
);

    localparam int DIV_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_FREQUENCY - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       sec_q, sec_d;
    logic             sat_q, sat_d;
    logic             wrap;

    assign wrap = (div_q == DIV_LAST);

    // The 60 s wrap only marks saturation; the following wrap (61 s) signals stale time
    assign timeout_o = wrap && sat_q && !clear_i;
    assign second_o  = sec_q;

    // Next-state: an accepted frame restarts the second, otherwise count and saturate
    always_comb begin
        div_d = div_q;
        sec_d = sec_q;
        sat_d = sat_q;
        if (clear_i) begin
            div_d = '0;
            sec_d = '0;
            sat_d = 1'b0;
        end else if (wrap) begin
            div_d = '0;
            if (sec_q == SEC_MAX) begin
                sat_d = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider and seconds registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            sec_q <= '0;
            sat_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sec_q <= sec_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/dcf77_time_decoder.sv
// rtl/dcf77_time_decoder.sv - serial DCF77 minute-frame validator and time publisher
module dcf77_time_decoder
    import dcf77_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 16000000
) (
    input  logic                 clk,
    input  logic                 reset,
    dcf77_time_decoder_if.slave  bus
);

    dcf_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic [5:0]            idx_q;
    logic                  par_min_q, par_hour_q, par_date_q;
    logic [2:0]            eval_err_q;
    logic [2:0]            eval_code;
    dcf_fields_t           fields_now;
    dcf_fields_t           fields_q;
    logic                  cest_q, tz_q, leap_q;
    logic                  frame_stb_q, frame_err_q;
    logic [2:0]            err_code_q;
    logic                  time_valid_q;
    logic                  accept, reject;
    logic                  cur_bit;
    logic                  timeout;
    logic [5:0]            second;

    assign cur_bit = frame_q[idx_q];

    assign fields_now.minute  = frame_q[MIN_LO +: 7];
    assign fields_now.hour    = frame_q[HOUR_LO +: 6];
    assign fields_now.day     = frame_q[DATE_LO +: 6];
    assign fields_now.weekday = frame_q[44:42];
    assign fields_now.month   = frame_q[49:45];
    assign fields_now.year    = frame_q[57:50];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and publish decision; strobes arriving outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE:    if (bus.dcf_sec) state_d = CHECK;
            CHECK:   if (idx_q == DATE_PAR) state_d = EVAL;
            EVAL:    state_d = PUBLISH;
            PUBLISH: begin
                state_d = IDLE;
                if (eval_err_q == ERR_NONE) accept = 1'b1;
                else                        reject = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // First failing check in priority order; parity accumulators hold 1 for an odd group
    always_comb begin
        eval_code = ERR_NONE;
        if (frame_q[MARKER0] || !frame_q[MARKER20]) begin
            eval_code = ERR_MARKER;
        end else if (frame_q[CEST] == frame_q[CET]) begin
            eval_code = ERR_TZ;
        end else if (par_min_q) begin
            eval_code = ERR_PMIN;
        end else if (par_hour_q) begin
            eval_code = ERR_PHOUR;
        end else if (par_date_q) begin
            eval_code = ERR_PDATE;
        end else if (!fields_in_range(fields_now)) begin
            eval_code = ERR_RANGE;
        end
    end

    // Frame capture, serial parity walk, verdict latch and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q      <= '0;
            idx_q        <= '0;
            par_min_q    <= 1'b0;
            par_hour_q   <= 1'b0;
            par_date_q   <= 1'b0;
            eval_err_q   <= ERR_NONE;
            fields_q     <= '0;
            cest_q       <= 1'b0;
            tz_q         <= 1'b0;
            leap_q       <= 1'b0;
            frame_stb_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            time_valid_q <= 1'b0;
        end else begin
            frame_stb_q <= accept;
            frame_err_q <= reject;
            case (state_q)
                IDLE: begin
                    if (bus.dcf_sec) begin
                        frame_q    <= bus.dcf_outputbits;
                        idx_q      <= '0;
                        par_min_q  <= 1'b0;
                        par_hour_q <= 1'b0;
                        par_date_q <= 1'b0;
                    end
                end
                CHECK: begin
                    idx_q <= idx_q + 6'd1;
                    if (idx_q >= MIN_LO && idx_q <= MIN_PAR) par_min_q <= par_min_q ^ cur_bit;
                    if (idx_q >= HOUR_LO && idx_q <= HOUR_PAR) par_hour_q <= par_hour_q ^ cur_bit;
                    if (idx_q >= DATE_LO && idx_q <= DATE_PAR) par_date_q <= par_date_q ^ cur_bit;
                end
                EVAL: eval_err_q <= eval_code;
                default: ;
            endcase
            if (accept) begin
                fields_q     <= fields_now;
                cest_q       <= frame_q[CEST];
                tz_q         <= frame_q[TZ_ANN];
                leap_q       <= frame_q[LEAP];
                time_valid_q <= 1'b1;
            end else if (timeout) begin
                time_valid_q <= 1'b0;
            end
            if (reject) err_code_q <= eval_err_q;
        end
    end

    dcf77_second_counter #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_second_counter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept),
        .second_o (second),
        .timeout_o(timeout)
    );

    assign bus.frame_stb     = frame_stb_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.err_code      = err_code_q;
    assign bus.time_valid    = time_valid_q;
    assign bus.minute        = fields_q.minute;
    assign bus.hour          = fields_q.hour;
    assign bus.day           = fields_q.day;
    assign bus.weekday       = fields_q.weekday;
    assign bus.month         = fields_q.month;
    assign bus.year          = fields_q.year;
    assign bus.cest          = cest_q;
    assign bus.tz_announce   = tz_q;
    assign bus.leap_announce = leap_q;
    assign bus.second        = second;

endmodule
